// File: rtl/ssd_pkg.sv
// Shared definitions for the two-digit seven-segment link.
// Segment codes are bit6..bit0; cat selects the nibble slot.
package ssd_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b0010111;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1111011;
  localparam logic [6:0] SEG_7 = 7'b0001110;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b0011111;
  localparam logic [6:0] SEG_A = 7'b0111111;
  localparam logic [6:0] SEG_B = 7'b1110011;
  localparam logic [6:0] SEG_C = 7'b1100001;
  localparam logic [6:0] SEG_D = 7'b1100111;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b0111001;

  localparam logic CAT_LO = 1'b1;
  localparam logic CAT_HI = 1'b0;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    SETTLE    = 2'd1,
    HOLD      = 2'd2
  } state_t;

endpackage

// File: rtl/ssd_segment_decoder_seg7.sv
// Combinational segment pattern to nibble decoder.
// Patterns outside the code table report legal = 0.
module seg7_to_nibble
  import ssd_pkg::*;
(
  input  logic [6:0] hex,
  output logic       legal,
  output logic [3:0] nibble
);

  // table lookup; unknown patterns decode as illegal zero
  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    unique case (hex)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_segment_decoder.sv
// Receive side of the multiplexed seven-segment link.
// Syncs hex/cat, waits for a stable pattern per phase, rebuilds the byte.
module ssd_segment_decoder
  import ssd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 262144,
  parameter int CNT_W          = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] hex,
  input  logic       cat,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       pattern_error,
  output logic       link_lost
);

  localparam logic [CNT_W-1:0] SETTLE_N  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [6:0]       hex_m, hex_s, hex_d;
  logic             cat_m, cat_s, cat_d;
  logic [1:0]       prime;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] idle_cnt;
  state_t           state, state_nx;
  logic             have_high;
  logic [3:0]       hi_nib;
  logic             legal;
  logic [3:0]       nib;
  logic             cat_edge, timeout, settle_done;
  logic             cap, err;
  logic             cap_hi, cap_lo, frame_done;

  seg7_to_nibble u_dec (
    .hex    (hex_s),
    .legal  (legal),
    .nibble (nib)
  );

  // two-flop synchronizers; prime masks edges until cat_d holds real data
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_m <= '0;
      hex_s <= '0;
      hex_d <= '0;
      cat_m <= 1'b0;
      cat_s <= 1'b0;
      cat_d <= 1'b0;
      prime <= 2'd0;
    end else begin
      hex_m <= hex;
      hex_s <= hex_m;
      hex_d <= hex_s;
      cat_m <= cat;
      cat_s <= cat_m;
      cat_d <= cat_s;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  assign cat_edge    = (prime == 2'd3) && (cat_s != cat_d);
  assign timeout     = !cat_edge && (idle_cnt == TIMEOUT_N - ONE);
  assign settle_done = (stable_cnt == SETTLE_N);

  // consecutive-stable counter, restarted by a new phase or a hex change
  always_ff @(posedge clk) begin
    if (reset)
      stable_cnt <= '0;
    else if (cat_edge || (hex_s != hex_d))
      stable_cnt <= ONE;
    else if (stable_cnt != SETTLE_N)
      stable_cnt <= stable_cnt + ONE;
  end

  // cycles since the last synced cat edge, saturating at the timeout
  always_ff @(posedge clk) begin
    if (reset)
      idle_cnt <= '0;
    else if (cat_edge)
      idle_cnt <= '0;
    else if (idle_cnt != TIMEOUT_N)
      idle_cnt <= idle_cnt + ONE;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_EDGE;
    else       state <= state_nx;
  end

  // FSM next state; a timeout drops back to waiting for the link
  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = WAIT_EDGE;
    end else begin
      unique case (state)
        WAIT_EDGE: if (cat_edge) state_nx = SETTLE;
        SETTLE: begin
          if (cat_edge)         state_nx = SETTLE;
          else if (settle_done) state_nx = HOLD;
        end
        HOLD:      if (cat_edge) state_nx = SETTLE;
        default:   state_nx = WAIT_EDGE;
      endcase
    end
  end

  // FSM outputs; an edge beats a same-cycle settle completion
  always_comb begin
    cap = 1'b0;
    err = 1'b0;
    if (!timeout && (state == SETTLE)) begin
      if (cat_edge) begin
        err = 1'b1;
      end else if (settle_done) begin
        cap = legal;
        err = !legal;
      end
    end
  end

  assign cap_hi     = cap && (cat_s == CAT_HI);
  assign cap_lo     = cap && (cat_s == CAT_LO);
  assign frame_done = cap_lo && have_high;

  // frame assembly, pulses and link status
  always_ff @(posedge clk) begin
    if (reset) begin
      value         <= 8'h00;
      value_valid   <= 1'b0;
      pattern_error <= 1'b0;
      link_lost     <= 1'b1;
      have_high     <= 1'b0;
      hi_nib        <= 4'h0;
    end else begin
      value_valid   <= frame_done;
      pattern_error <= err;
      if (timeout) begin
        link_lost <= 1'b1;
        have_high <= 1'b0;
      end else begin
        if (err || cap_lo) have_high <= 1'b0;
        if (cap_hi) begin
          hi_nib    <= nib;
          have_high <= 1'b1;
        end
        if (frame_done) begin
          value     <= {hi_nib, nib};
          link_lost <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_segment_decoder.sv
// Directed bench for ssd_segment_decoder.
// Frame table plus hand sequences for alignment, errors, timeout, reset.
module tb_ssd_segment_decoder;

  localparam int P  = 64;
  localparam int TO = 1024;
  localparam int NV = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] hex;
  logic       cat;
  logic [7:0] value;
  logic       value_valid;
  logic       pattern_error;
  logic       link_lost;

  int checks = 0;
  int errors = 0;
  int vv_cnt = 0;
  int perr_cnt = 0;
  int overlap = 0;
  logic [7:0] last_v = 8'h00;

  logic [6:0] segs [16];

  typedef struct {
    logic [6:0] hi;
    logic [6:0] lo;
    int         n_valid;
    logic [7:0] val;
    int         n_err;
  } vec_t;

  vec_t tbl [NV];

  ssd_segment_decoder #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (11)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hex           (hex),
    .cat           (cat),
    .value         (value),
    .value_valid   (value_valid),
    .pattern_error (pattern_error),
    .link_lost     (link_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (value_valid) begin
      vv_cnt++;
      last_v = value;
    end
    if (pattern_error) perr_cnt++;
    if (value_valid && pattern_error) overlap++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic phase(input logic c, input logic [6:0] h, input int len);
    @(negedge clk);
    cat = c;
    hex = h;
    repeat (len - 1) @(negedge clk);
  endtask

  function automatic vec_t fr(input logic [7:0] b);
    vec_t v;
    v.hi      = segs[b[7:4]];
    v.lo      = segs[b[3:0]];
    v.n_valid = 1;
    v.val     = b;
    v.n_err   = 0;
    return v;
  endfunction

  task automatic hold_reset(input logic c);
    @(negedge clk);
    reset = 1'b1;
    cat   = c;
    hex   = 7'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_valid"}, int'(value_valid), 0);
    chk({tag, "_perr"}, int'(pattern_error), 0);
    chk({tag, "_lost"}, int'(link_lost), 1);
  endtask

  initial begin
    segs[0]  = 7'b1111110; segs[1]  = 7'b0000110;
    segs[2]  = 7'b1101101; segs[3]  = 7'b1001111;
    segs[4]  = 7'b0010111; segs[5]  = 7'b1011011;
    segs[6]  = 7'b1111011; segs[7]  = 7'b0001110;
    segs[8]  = 7'b1111111; segs[9]  = 7'b0011111;
    segs[10] = 7'b0111111; segs[11] = 7'b1110011;
    segs[12] = 7'b1100001; segs[13] = 7'b1100111;
    segs[14] = 7'b1111001; segs[15] = 7'b0111001;

    tbl[0]  = fr(8'h3C);
    tbl[1]  = fr(8'hA5);
    tbl[2]  = fr(8'hFF);
    tbl[3]  = fr(8'h01);
    tbl[4]  = fr(8'h23);
    tbl[5]  = fr(8'h45);
    tbl[6]  = fr(8'h67);
    tbl[7]  = fr(8'h89);
    tbl[8]  = fr(8'hAB);
    tbl[9]  = fr(8'hCD);
    tbl[10] = fr(8'hEF);
    tbl[11] = '{hi: segs[1], lo: 7'b0000000,
                n_valid: 0, val: 8'hEF, n_err: 1};
    tbl[12] = fr(8'h88);
    tbl[13] = fr(8'h88);
    tbl[14] = fr(8'h5A);

    reset = 1'b1;
    cat   = 1'b1;
    hex   = 7'h00;

    hold_reset(1'b1);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      vv_cnt   = 0;
      perr_cnt = 0;
      phase(1'b0, tbl[i].hi, P);
      phase(1'b1, tbl[i].lo, P);
      chk($sformatf("row%0d_nvalid", i), vv_cnt, tbl[i].n_valid);
      chk($sformatf("row%0d_value", i), int'(value), int'(tbl[i].val));
      chk($sformatf("row%0d_perr", i), perr_cnt, tbl[i].n_err);
      chk($sformatf("row%0d_lost", i), int'(link_lost), 0);
    end

    hold_reset(1'b0);
    check_reset_outputs("reset2");
    reset = 1'b0;
    vv_cnt   = 0;
    perr_cnt = 0;
    repeat (5) @(negedge clk);
    phase(1'b1, segs[2], P);
    chk("align_drop_nvalid", vv_cnt, 0);
    phase(1'b0, segs[1], P);
    phase(1'b1, segs[2], P);
    chk("align_nvalid", vv_cnt, 1);
    chk("align_value", int'(last_v), 'h12);
    chk("align_perr", perr_cnt, 0);
    chk("align_lost", int'(link_lost), 0);

    vv_cnt   = 0;
    perr_cnt = 0;
    phase(1'b0, 7'b1010101, P);
    phase(1'b1, segs[7], P);
    chk("illegal_hi_perr", perr_cnt, 1);
    chk("illegal_hi_nvalid", vv_cnt, 0);
    chk("illegal_hi_value", int'(value), 'h12);

    vv_cnt   = 0;
    perr_cnt = 0;
    for (int j = 0; j < P; j++) begin
      @(negedge clk);
      cat = 1'b0;
      hex = j[3] ? segs[3] : segs[9];
    end
    chk("glitch_no_perr_yet", perr_cnt, 0);
    phase(1'b1, segs[14], P);
    chk("glitch_perr", perr_cnt, 1);
    chk("glitch_nvalid", vv_cnt, 0);
    phase(1'b0, segs[9], P);
    phase(1'b1, segs[14], P);
    chk("recover_nvalid", vv_cnt, 1);
    chk("recover_value", int'(value), 'h9E);
    chk("recover_perr", perr_cnt, 1);

    vv_cnt   = 0;
    perr_cnt = 0;
    phase(1'b0, segs[4], P);
    @(negedge clk);
    cat = 1'b1;
    hex = segs[4];
    repeat (TO + 2) @(posedge clk);
    #1;
    chk("timeout_before", int'(link_lost), 0);
    @(posedge clk);
    #1;
    chk("timeout_at", int'(link_lost), 1);
    chk("timeout_nvalid", vv_cnt, 1);
    chk("timeout_value", int'(value), 'h44);
    repeat (20) @(negedge clk);
    chk("timeout_hold_value", int'(value), 'h44);
    chk("timeout_hold_lost", int'(link_lost), 1);

    @(negedge clk);
    cat = 1'b0;
    hex = segs[7];
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    reset    = 1'b0;
    vv_cnt   = 0;
    perr_cnt = 0;
    repeat (10) @(negedge clk);
    phase(1'b1, segs[11], P);
    phase(1'b0, segs[7], P);
    chk("midreset_lost_pre", int'(link_lost), 1);
    phase(1'b1, segs[11], P);
    chk("midreset_nvalid", vv_cnt, 1);
    chk("midreset_value", int'(value), 'h7B);
    chk("midreset_perr", perr_cnt, 0);
    chk("midreset_lost", int'(link_lost), 0);

    chk("valid_perr_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
